// File: rtl/csr_commit_pkg.sv
// Shared encodings for the write-back CSR commit controller:
// CSR op codes, exception cause bit positions and FSM states.
package csr_commit_pkg;

    localparam logic [1:0] CSR_OP_NONE = 2'b00;
    localparam logic [1:0] CSR_OP_RD   = 2'b01;
    localparam logic [1:0] CSR_OP_WR   = 2'b10;
    localparam logic [1:0] CSR_OP_XCHG = 2'b11;

    // Bit positions inside csr_exc; a higher index means a higher priority
    localparam int EXC_INT  = 5;
    localparam int EXC_ADEF = 4;
    localparam int EXC_ALE  = 3;
    localparam int EXC_BRK  = 2;
    localparam int EXC_INE  = 1;
    localparam int EXC_SYS  = 0;
    localparam int EXC_W    = 6;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority one-hot encoder for exception causes.
// The most significant requesting bit wins; no request gives all zeros.
module exc_prio_enc
    import csr_commit_pkg::*;
(
    input  logic [EXC_W-1:0] i_req,
    output logic [EXC_W-1:0] o_grant
);

    assign o_grant[EXC_W-1] = i_req[EXC_W-1];

    generate
        for (genvar gi = 0; gi < EXC_W - 1; gi++) begin : g_grant
            assign o_grant[gi] = i_req[gi] & ~(|i_req[EXC_W-1:gi+1]);
        end
    endgenerate

endmodule

// File: rtl/csr_commit_ctrl.sv
// Write-back CSR commit controller: issues CSR read/write traffic, exception
// and ertn commit strobes, and holds a redirect handshake toward fetch.
module csr_commit_ctrl
    import csr_commit_pkg::*;
#(
    parameter logic [31:0] RST_PC = 32'h1c000000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [31:0]      wb_pc,
    input  logic [1:0]       wb_csr_op,
    input  logic [13:0]      wb_csr_num,
    input  logic [31:0]      wb_rj_value,
    input  logic [31:0]      wb_rd_value,
    input  logic [4:0]       wb_rd_addr,
    input  logic [4:0]       wb_exc,
    input  logic             wb_ertn,
    output logic             csr_re,
    output logic             csr_we,
    output logic [13:0]      csr_rd_num,
    output logic [13:0]      csr_wr_num,
    output logic [31:0]      csr_wr_mask,
    output logic [31:0]      csr_wr_value,
    output logic [EXC_W-1:0] csr_exc,
    output logic             csr_ertn_flush,
    output logic [31:0]      csr_wb_pc,
    input  logic [31:0]      csr_rd_value,
    input  logic [31:0]      csr_eentry_pc,
    input  logic [31:0]      csr_eertn_pc,
    input  logic             has_int,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [31:0]      redir_pc,
    output logic             flush
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_rf_we;
    logic [4:0]        r_rf_waddr;
    logic [31:0]       r_rf_wdata;
    logic [31:0]       r_redir_pc;

    logic              w_accept;
    logic              w_trap;
    logic              w_exc_take;
    logic              w_ertn_take;
    logic              w_csr_acc;
    logic              w_csr_wr;
    logic [EXC_W-1:0]  w_grant;

    assign wb_ready    = (r_state == ST_IDLE);
    assign w_accept    = wb_valid & wb_ready;
    assign w_trap      = has_int | (|wb_exc);
    assign w_exc_take  = w_accept & w_trap;
    // A trap suppresses both the CSR op and ertn of the same instruction
    assign w_ertn_take = w_accept & ~w_trap & wb_ertn;
    assign w_csr_acc   = w_accept & ~w_trap & (wb_csr_op != CSR_OP_NONE);
    assign w_csr_wr    = w_csr_acc & ((wb_csr_op == CSR_OP_WR) | (wb_csr_op == CSR_OP_XCHG));

    exc_prio_enc u_exc_prio_enc (
        .i_req   ({has_int, wb_exc}),
        .o_grant (w_grant)
    );

    assign csr_exc        = w_exc_take ? w_grant : '0;
    assign csr_wb_pc      = w_exc_take ? wb_pc : '0;
    assign csr_ertn_flush = w_ertn_take;
    assign csr_re         = w_csr_acc;
    assign csr_rd_num     = w_csr_acc ? wb_csr_num : '0;
    assign csr_we         = w_csr_wr;
    assign csr_wr_num     = w_csr_wr ? wb_csr_num : '0;
    assign csr_wr_value   = w_csr_wr ? wb_rd_value : '0;
    assign csr_wr_mask    = !w_csr_wr ? '0 :
                            (wb_csr_op == CSR_OP_XCHG) ? wb_rj_value : '1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_exc_take | w_ertn_take) w_state_next = ST_REDIRECT;
            ST_REDIRECT: if (redir_ready)              w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // The old CSR value is captured in the accept cycle, before the write lands
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_redir_pc <= RST_PC;
        end else begin
            r_rf_we <= w_csr_acc & (wb_rd_addr != 5'd0);
            if (w_csr_acc) begin
                r_rf_waddr <= wb_rd_addr;
                r_rf_wdata <= csr_rd_value;
            end
            if (w_exc_take) begin
                r_redir_pc <= csr_eentry_pc;
            end else if (w_ertn_take) begin
                r_redir_pc <= csr_eertn_pc;
            end
        end
    end

    assign rf_we       = r_rf_we;
    assign rf_waddr    = r_rf_waddr;
    assign rf_wdata    = r_rf_wdata;
    assign redir_valid = (r_state == ST_REDIRECT);
    assign flush       = redir_valid;
    assign redir_pc    = r_redir_pc;

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Self-checking bench for csr_commit_ctrl: CSR file environment, rule-level
// reference model, vector table, directed corner sequences and random traffic.
module tb_csr_commit_ctrl;
    import csr_commit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h1c000000;

    logic        clk;
    logic        resetn;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_pc;
    logic [1:0]  wb_csr_op;
    logic [13:0] wb_csr_num;
    logic [31:0] wb_rj_value;
    logic [31:0] wb_rd_value;
    logic [4:0]  wb_rd_addr;
    logic [4:0]  wb_exc;
    logic        wb_ertn;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_rd_num;
    logic [13:0] csr_wr_num;
    logic [31:0] csr_wr_mask;
    logic [31:0] csr_wr_value;
    logic [5:0]  csr_exc;
    logic        csr_ertn_flush;
    logic [31:0] csr_wb_pc;
    logic [31:0] csr_rd_value;
    logic [31:0] csr_eentry_pc;
    logic [31:0] csr_eertn_pc;
    logic        has_int;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        flush;

    csr_commit_ctrl #(.RST_PC(RST_PC)) dut (
        .clk(clk), .resetn(resetn),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc),
        .wb_csr_op(wb_csr_op), .wb_csr_num(wb_csr_num),
        .wb_rj_value(wb_rj_value), .wb_rd_value(wb_rd_value),
        .wb_rd_addr(wb_rd_addr), .wb_exc(wb_exc), .wb_ertn(wb_ertn),
        .csr_re(csr_re), .csr_we(csr_we),
        .csr_rd_num(csr_rd_num), .csr_wr_num(csr_wr_num),
        .csr_wr_mask(csr_wr_mask), .csr_wr_value(csr_wr_value),
        .csr_exc(csr_exc), .csr_ertn_flush(csr_ertn_flush), .csr_wb_pc(csr_wb_pc),
        .csr_rd_value(csr_rd_value), .csr_eentry_pc(csr_eentry_pc),
        .csr_eertn_pc(csr_eertn_pc), .has_int(has_int),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .redir_valid(redir_valid), .redir_ready(redir_ready),
        .redir_pc(redir_pc), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file environment driven by the DUT bus; the bench only uses CSR numbers below 64
    logic [31:0] csr_file [0:63];
    logic        env_clear;
    assign csr_rd_value = csr_file[csr_rd_num[5:0]];

    always @(posedge clk) begin
        if (env_clear) begin
            for (int i = 0; i < 64; i++) csr_file[i] <= 32'h0;
        end else if (csr_we) begin
            csr_file[csr_wr_num[5:0]] <= (csr_file[csr_wr_num[5:0]] & ~csr_wr_mask)
                                       | (csr_wr_value & csr_wr_mask);
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:63];
    bit          m_redir, n_redir;
    logic [31:0] m_redir_pc, n_redir_pc;
    bit          m_rf_we, n_rf_we;
    logic [4:0]  m_rf_waddr, n_rf_waddr;
    logic [31:0] m_rf_wdata, n_rf_wdata;
    bit          n_mem_we;
    logic [5:0]  n_mem_idx;
    logic [31:0] n_mem_val;

    int checks = 0;
    int errors = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_redir    = 0;
        m_redir_pc = RST_PC;
        m_rf_we    = 0;
        m_rf_waddr = '0;
        m_rf_wdata = '0;
        n_mem_we   = 0;
    endtask

    task automatic idle_inputs();
        wb_valid = 0; wb_pc = '0; wb_csr_op = CSR_OP_NONE; wb_csr_num = '0;
        wb_rj_value = '0; wb_rd_value = '0; wb_rd_addr = '0; wb_exc = '0;
        wb_ertn = 0; has_int = 0; redir_ready = 1; csr_eentry_pc = '0; csr_eertn_pc = '0;
    endtask

    // Check every output against the model at the falling edge and compute next state
    task automatic step_begin();
        bit         acc, trap, acc_csr, acc_wr;
        logic [5:0] req, e_exc;
        logic [31:0] e_mask;
        @(negedge clk);
        acc     = wb_valid && !m_redir;
        trap    = has_int || (wb_exc != 5'd0);
        req     = {has_int, wb_exc};
        e_exc   = '0;
        if (acc && trap) begin
            for (int i = 5; i >= 0; i--) begin
                if (req[i]) begin
                    e_exc[i] = 1'b1;
                    break;
                end
            end
        end
        acc_csr = acc && !trap && (wb_csr_op != CSR_OP_NONE);
        acc_wr  = acc_csr && (wb_csr_op[1] == 1'b1);
        e_mask  = !acc_wr ? 32'h0 : (wb_csr_op == CSR_OP_XCHG) ? wb_rj_value : 32'hffffffff;
        if (acc)
            $display("txn t=%0t pc=%08h op=%0d num=%0h exc=%05b int=%0b ertn=%0b",
                     $time, wb_pc, wb_csr_op, wb_csr_num, wb_exc, has_int, wb_ertn);

        chk1 ("wb_ready", wb_ready, !m_redir);
        chk32("csr_exc", 32'(csr_exc), 32'(e_exc));
        chk32("csr_wb_pc", csr_wb_pc, (acc && trap) ? wb_pc : 32'h0);
        chk1 ("csr_re", csr_re, acc_csr);
        chk32("csr_rd_num", 32'(csr_rd_num), acc_csr ? 32'(wb_csr_num) : 32'h0);
        chk1 ("csr_we", csr_we, acc_wr);
        chk32("csr_wr_num", 32'(csr_wr_num), acc_wr ? 32'(wb_csr_num) : 32'h0);
        chk32("csr_wr_value", csr_wr_value, acc_wr ? wb_rd_value : 32'h0);
        chk32("csr_wr_mask", csr_wr_mask, e_mask);
        chk1 ("csr_ertn_flush", csr_ertn_flush, acc && !trap && wb_ertn);
        chk1 ("rf_we", rf_we, m_rf_we);
        if (m_rf_we) begin
            chk32("rf_waddr", 32'(rf_waddr), 32'(m_rf_waddr));
            chk32("rf_wdata", rf_wdata, m_rf_wdata);
        end
        chk1 ("redir_valid", redir_valid, m_redir);
        chk1 ("flush", flush, m_redir);
        if (m_redir) chk32("redir_pc", redir_pc, m_redir_pc);

        n_rf_we    = acc_csr && (wb_rd_addr != 5'd0);
        n_rf_waddr = acc_csr ? wb_rd_addr : m_rf_waddr;
        n_rf_wdata = acc_csr ? ref_mem[wb_csr_num[5:0]] : m_rf_wdata;
        n_mem_we   = acc_wr;
        n_mem_idx  = wb_csr_num[5:0];
        n_mem_val  = (ref_mem[wb_csr_num[5:0]] & ~e_mask) | (wb_rd_value & e_mask);
        n_redir    = m_redir;
        n_redir_pc = m_redir_pc;
        if (m_redir) begin
            if (redir_ready) n_redir = 0;
        end else if (acc && trap) begin
            n_redir = 1; n_redir_pc = csr_eentry_pc;
        end else if (acc && wb_ertn) begin
            n_redir = 1; n_redir_pc = csr_eertn_pc;
        end
    endtask

    task automatic step_end();
        @(posedge clk);
        m_rf_we = n_rf_we; m_rf_waddr = n_rf_waddr; m_rf_wdata = n_rf_wdata;
        m_redir = n_redir; m_redir_pc = n_redir_pc;
        if (n_mem_we) ref_mem[n_mem_idx] = n_mem_val;
        n_mem_we = 0;
        #1;
    endtask

    task automatic step();
        step_begin();
        step_end();
    endtask

    task automatic csr_txn(input logic [1:0] op, input logic [13:0] num,
                           input logic [31:0] rj, input logic [31:0] rdv, input logic [4:0] rd);
        idle_inputs();
        wb_valid = 1; wb_csr_op = op; wb_csr_num = num;
        wb_rj_value = rj; wb_rd_value = rdv; wb_rd_addr = rd; wb_pc = 32'h1c000040;
    endtask

    typedef struct {
        logic       valid;
        logic       hint;
        logic [4:0] exc;
        logic       ertn;
        logic [1:0] op;
        logic [5:0] e_exc;
        logic       e_re;
        logic       e_we;
        logic       e_fl;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 5'b00000, 1'b0, CSR_OP_RD,   6'b000000, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 5'b00000, 1'b0, CSR_OP_WR,   6'b000000, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 5'b00000, 1'b0, CSR_OP_XCHG, 6'b000000, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 5'b00001, 1'b0, CSR_OP_NONE, 6'b000001, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 5'b01001, 1'b0, CSR_OP_RD,   6'b001000, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 5'b10100, 1'b0, CSR_OP_WR,   6'b010000, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 5'b00010, 1'b0, CSR_OP_WR,   6'b100000, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 5'b00100, 1'b1, CSR_OP_NONE, 6'b000100, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 5'b00000, 1'b1, CSR_OP_RD,   6'b000000, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 5'b11111, 1'b1, CSR_OP_XCHG, 6'b000000, 1'b0, 1'b0, 1'b0};

        // Reset values
        idle_inputs();
        resetn = 0;
        env_clear = 1;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1 ("rst_wb_ready", wb_ready, 1'b1);
        chk1 ("rst_rf_we", rf_we, 1'b0);
        chk32("rst_rf_waddr", 32'(rf_waddr), 32'h0);
        chk32("rst_rf_wdata", rf_wdata, 32'h0);
        chk1 ("rst_redir_valid", redir_valid, 1'b0);
        chk32("rst_redir_pc", redir_pc, RST_PC);
        chk1 ("rst_csr_we", csr_we, 1'b0);
        resetn = 1;
        env_clear = 0;
        @(posedge clk); #1;

        // Vector table, each followed by a drain cycle that completes any redirect
        for (int v = 0; v < 10; v++) begin
            idle_inputs();
            wb_valid = vecs[v].valid; has_int = vecs[v].hint; wb_exc = vecs[v].exc;
            wb_ertn = vecs[v].ertn; wb_csr_op = vecs[v].op; wb_csr_num = 14'h5;
            wb_rd_addr = 5'd3; wb_rd_value = 32'h0f0f0f0f; wb_rj_value = 32'h00ff00ff;
            wb_pc = 32'h1c000200 + 32'(v * 4);
            csr_eentry_pc = 32'h1c008000; csr_eertn_pc = 32'h1c000300;
            step_begin();
            chk32("vec_exc", 32'(csr_exc), 32'(vecs[v].e_exc));
            chk1 ("vec_re", csr_re, vecs[v].e_re);
            chk1 ("vec_we", csr_we, vecs[v].e_we);
            chk1 ("vec_ertn", csr_ertn_flush, vecs[v].e_fl);
            step_end();
            idle_inputs();
            step();
        end

        // csrwr with old value readback
        csr_txn(CSR_OP_WR, 14'h30, 32'h0, 32'h12345678, 5'd0);
        step();
        csr_txn(CSR_OP_WR, 14'h30, 32'h0, 32'hdeadbeef, 5'd5);
        step_begin();
        chk1 ("wr_we", csr_we, 1'b1);
        chk32("wr_mask", csr_wr_mask, 32'hffffffff);
        step_end();
        idle_inputs();
        step_begin();
        chk1 ("wr_rf_we", rf_we, 1'b1);
        chk32("wr_rf_waddr", 32'(rf_waddr), 32'd5);
        chk32("wr_rf_wdata", rf_wdata, 32'h12345678);
        step_end();

        // Back-to-back wr then xchg on SAVE0
        csr_txn(CSR_OP_WR, 14'h30, 32'h0, 32'haaaabbbb, 5'd0);
        step();
        csr_txn(CSR_OP_XCHG, 14'h30, 32'h0000ffff, 32'h11112222, 5'd7);
        step_begin();
        chk32("xchg_mask", csr_wr_mask, 32'h0000ffff);
        step_end();
        idle_inputs();
        step_begin();
        chk32("xchg_rf_wdata", rf_wdata, 32'haaaabbbb);
        step_end();
        chk32("xchg_save0", csr_file[6'h30], 32'haaaa2222);

        // SYS trap with a slow frontend
        idle_inputs();
        wb_valid = 1; wb_exc = 5'b00001; wb_pc = 32'h1c000100;
        csr_eentry_pc = 32'h1c008000; redir_ready = 0;
        step_begin();
        chk32("sys_exc", 32'(csr_exc), 32'h01);
        chk32("sys_wb_pc", csr_wb_pc, 32'h1c000100);
        step_end();
        for (int k = 0; k < 3; k++) begin
            csr_txn(CSR_OP_WR, 14'h2, 32'h0, 32'h55555555, 5'd4);
            redir_ready = 0;
            step_begin();
            chk1 ("sys_hold_valid", redir_valid, 1'b1);
            chk32("sys_hold_pc", redir_pc, 32'h1c008000);
            chk1 ("sys_hold_ready", wb_ready, 1'b0);
            step_end();
        end
        idle_inputs();
        step();
        step_begin();
        chk1("sys_back_idle", wb_ready, 1'b1);
        step_end();

        // Interrupt beats INE and suppresses the write
        csr_txn(CSR_OP_WR, 14'h30, 32'h0, 32'h99999999, 5'd5);
        has_int = 1; wb_exc = 5'b00010; csr_eentry_pc = 32'h1c00a000;
        step_begin();
        chk32("int_exc", 32'(csr_exc), 32'h20);
        chk1 ("int_we", csr_we, 1'b0);
        step_end();
        idle_inputs();
        step_begin();
        chk1("int_rf_we", rf_we, 1'b0);
        step_end();

        // ertn, then asynchronous reset in the middle of the redirect
        idle_inputs();
        wb_valid = 1; wb_ertn = 1; csr_eertn_pc = 32'h1c000104; redir_ready = 0;
        step_begin();
        chk1("ertn_pulse", csr_ertn_flush, 1'b1);
        step_end();
        idle_inputs();
        redir_ready = 0;
        step_begin();
        chk1 ("ertn_pulse_end", csr_ertn_flush, 1'b0);
        chk32("ertn_redir_pc", redir_pc, 32'h1c000104);
        #2;
        resetn = 0;
        #1;
        chk1 ("arst_redir_valid", redir_valid, 1'b0);
        chk32("arst_redir_pc", redir_pc, RST_PC);
        chk1 ("arst_wb_ready", wb_ready, 1'b1);
        model_reset();
        @(posedge clk); #1;
        resetn = 1;

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            wb_valid      = ($urandom_range(0, 3) != 0);
            wb_csr_op     = 2'($urandom_range(0, 3));
            wb_csr_num    = 14'($urandom_range(0, 7));
            wb_rj_value   = $urandom;
            wb_rd_value   = $urandom;
            wb_rd_addr    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb_exc        = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            has_int       = ($urandom_range(0, 9) == 0);
            wb_ertn       = ($urandom_range(0, 7) == 0);
            wb_pc         = $urandom;
            csr_eentry_pc = $urandom;
            csr_eertn_pc  = $urandom;
            redir_ready   = ($urandom_range(0, 1) == 1);
            step();
        end
        idle_inputs();
        repeat (3) step();
        for (int i = 0; i < 8; i++) chk32("csr_file_vs_model", csr_file[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
